// File: rtl/lime_pkg.sv
// ============================================================================
// Module : lime_pkg
// Brief  : Shared LIME constants: opcodes, branch types, IR field positions.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lime_pkg;

  localparam int unsigned LIME_WIDTH = 16;

  localparam logic [2:0] c_OP_3R  = 3'b000;
  localparam logic [2:0] c_OP_2RI = 3'b001;
  localparam logic [2:0] c_OP_RI  = 3'b010;
  localparam logic [2:0] c_OP_L   = 3'b011;
  localparam logic [2:0] c_OP_UJ  = 3'b100;

  localparam logic [1:0] c_BR_BEQ = 2'b00;
  localparam logic [1:0] c_BR_BNE = 2'b01;
  localparam logic [1:0] c_BR_BLT = 2'b10;
  localparam logic [1:0] c_BR_BGE = 2'b11;

  localparam int unsigned c_OPC_LSB  = 0;
  localparam int unsigned c_OPC_W    = 3;
  localparam int unsigned c_CTRL_W   = 7;
  localparam int unsigned c_REG_W    = 3;
  localparam int unsigned c_RD_LSB   = 7;
  localparam int unsigned c_RS1_LSB  = 10;
  localparam int unsigned c_RS2_LSB  = 13;
  localparam int unsigned c_IMM6_LSB = 10;
  localparam int unsigned c_IMM9_LSB = 7;
  localparam int unsigned c_IR_MSB   = 15;

  // Opcodes above UJ have no defined meaning.
  function automatic logic is_illegal_opcode(input logic [2:0] op);
    return (op > c_OP_UJ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
// Module : branch_cond
// Brief  : Combinational branch decision from ALU flags and branch type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond
  import lime_pkg::*;
(
  input  logic [1:0] BranchType,
  input  logic       alu_zero,
  input  logic       alu_lt,
  output logic       br_taken
);

  always_comb begin
    br_taken = 1'b0;
    case (BranchType)
      c_BR_BEQ: br_taken = alu_zero;
      c_BR_BNE: br_taken = !alu_zero;
      c_BR_BLT: br_taken = alu_lt;
      c_BR_BGE: br_taken = !alu_lt;
      default:  br_taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_ir_unit.sv
// ============================================================================
// Module : pc_ir_unit
// Brief  : PC, IR, ALU-out and MDR registers with IR decode and branch gating.
//          Optional feature macro: ILLEGAL_OP_EN (sticky illegal-opcode flag).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ir_unit
  import lime_pkg::*;
#(
  parameter int unsigned      WIDTH    = LIME_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IRWrite,
  input  logic             PCWrite,
  input  logic             PCSrc,
  input  logic             IoD,
  input  logic             Branch,
  input  logic [1:0]       BranchType,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [6:0]       ctrl,
  output logic [2:0]       rd,
  output logic [2:0]       rs1,
  output logic [2:0]       rs2,
  output logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] mdr,
  output logic             br_taken,
  output logic             illegal_op
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_alu_out;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_pc_load;
  logic             w_br_taken;
  logic [2:0]       w_opcode;
  logic             w_sign;

  branch_cond u_branch_cond (
    .BranchType (BranchType),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .br_taken   (w_br_taken)
  );

  assign w_pc_next = PCSrc ? r_alu_out : alu_result;
  assign w_pc_load = PCWrite && (!Branch || w_br_taken);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
    end else begin
      r_alu_out <= alu_result;
      r_mdr     <= mem_rdata;
      if (IRWrite)   r_ir <= mem_rdata;
      if (w_pc_load) r_pc <= w_pc_next;
    end
  end

  assign w_opcode = r_ir[c_OPC_LSB +: c_OPC_W];
  assign w_sign   = r_ir[c_IR_MSB];

  always_comb begin
    imm = '0;
    case (w_opcode)
      c_OP_2RI:        imm = {{(WIDTH-3){w_sign}}, r_ir[c_RS2_LSB +: 3]};
      c_OP_RI:         imm = {{(WIDTH-6){w_sign}}, r_ir[c_IMM6_LSB +: 6]};
      c_OP_L, c_OP_UJ: imm = {{(WIDTH-9){w_sign}}, r_ir[c_IMM9_LSB +: 9]};
      default:         imm = '0;
    endcase
  end

`ifdef ILLEGAL_OP_EN
  logic r_illegal_op;

  // Judged on the incoming word so the flag lands on the same edge as the IR load.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_illegal_op <= 1'b0;
    end else if (IRWrite && is_illegal_opcode(mem_rdata[c_OPC_LSB +: c_OPC_W])) begin
      r_illegal_op <= 1'b1;
    end
  end

  assign illegal_op = r_illegal_op;
`else
  assign illegal_op = 1'b0;
`endif

  assign mem_addr = IoD ? r_alu_out : r_pc;
  assign pc       = r_pc;
  assign ctrl     = r_ir[c_CTRL_W-1:0];
  assign rd       = r_ir[c_RD_LSB  +: c_REG_W];
  assign rs1      = r_ir[c_RS1_LSB +: c_REG_W];
  assign rs2      = r_ir[c_RS2_LSB +: c_REG_W];
  assign alu_out  = r_alu_out;
  assign mdr      = r_mdr;
  assign br_taken = w_br_taken;

endmodule

`default_nettype wire

// File: tb/tb_pc_ir_unit.sv
// ============================================================================
// Module : tb_pc_ir_unit
// Brief  : Directed plus randomized self-checking bench for pc_ir_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_ir_unit;

  localparam int      c_MASK     = 'hFFFF;
  localparam int      c_RESET_PC = 'h0040;

  logic        CLK;
  logic        Reset;
  logic        IRWrite, PCWrite, PCSrc, IoD, Branch;
  logic [1:0]  BranchType;
  logic [15:0] alu_result;
  logic        alu_zero, alu_lt;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr, pc, imm, alu_out, mdr;
  logic [6:0]  ctrl;
  logic [2:0]  rd, rs1, rs2;
  logic        br_taken, illegal_op;

  int checks   = 0;
  int failures = 0;

  // Architectural model state
  int m_pc, m_ir, m_alu, m_mdr;
  bit m_ill;

  pc_ir_unit #(.WIDTH(16), .RESET_PC(16'h0040)) dut (
    .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .IoD(IoD), .Branch(Branch), .BranchType(BranchType),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .pc(pc), .ctrl(ctrl),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_out(alu_out),
    .mdr(mdr), .br_taken(br_taken), .illegal_op(illegal_op)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic int exp_imm(input int ir);
    int r;
    case (ir % 8)
      1:       r = sext((ir / 8192) % 8, 3);
      2:       r = sext((ir / 1024) % 64, 6);
      3, 4:    r = sext((ir / 128) % 512, 9);
      default: r = 0;
    endcase
    return r & c_MASK;
  endfunction

  function automatic bit exp_taken(input int bt, input bit z, input bit lt);
    case (bt)
      0: return z;
      1: return !z;
      2: return lt;
      default: return !lt;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = c_RESET_PC; m_ir = 0; m_alu = 0; m_mdr = 0; m_ill = 0;
  endtask

  task automatic drive(input bit irw, input bit pcw, input bit src, input bit iod,
                       input bit br, input int bt, input int res, input bit z,
                       input bit lt, input int rdata);
    IRWrite = irw; PCWrite = pcw; PCSrc = src; IoD = iod; Branch = br;
    BranchType = bt[1:0]; alu_result = res[15:0]; alu_zero = z; alu_lt = lt;
    mem_rdata = rdata[15:0];
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    bit tk;
    int nxt;
    #1;
    tk = exp_taken(int'(BranchType), alu_zero, alu_lt);
    chk("br_taken", br_taken, tk);
    chk("mem_addr", mem_addr, IoD ? m_alu : m_pc);
    chk("imm", imm, exp_imm(m_ir));
    nxt = m_pc;
    if (PCWrite && (!Branch || tk)) nxt = PCSrc ? m_alu : int'(alu_result);
    if (IRWrite) begin
      m_ir = int'(mem_rdata);
`ifdef ILLEGAL_OP_EN
      if (m_ir % 8 >= 5) m_ill = 1;
`endif
    end
    m_alu = int'(alu_result);
    m_mdr = int'(mem_rdata);
    m_pc  = nxt;
    @(posedge CLK);
    #1;
    chk("pc", pc, m_pc);
    chk("alu_out", alu_out, m_alu);
    chk("mdr", mdr, m_mdr);
    chk("ctrl", ctrl, m_ir % 128);
    chk("rd", rd, (m_ir / 128) % 8);
    chk("rs1", rs1, (m_ir / 1024) % 8);
    chk("rs2", rs2, (m_ir / 8192) % 8);
    chk("illegal_op", illegal_op, m_ill);
    @(negedge CLK);
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 Reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", pc, c_RESET_PC);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_illegal", illegal_op, 0);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;

    // Fetch on the first edge after reset release
    drive(1, 1, 0, 0, 0, 0, 'h0002, 0, 0, 'h1A42);
    cycle();
    chk("fetch_ctrl", ctrl, 'h42);
    chk("fetch_rd", rd, 4);
    chk("fetch_rs1", rs1, 6);
    chk("fetch_rs2", rs2, 0);
    chk("fetch_pc", pc, 'h0002);

    // Taken beq: target computed, then loaded from alu_out
    drive(0, 0, 0, 0, 0, 0, 'h0010, 0, 0, 'h0000);
    cycle();
    drive(0, 1, 1, 0, 1, 0, 'h7777, 1, 0, 'h0000);
    cycle();
    chk("beq_taken_pc", pc, 'h0010);

    // Untaken blt
    drive(0, 0, 0, 0, 0, 0, 'h0030, 0, 0, 'h0000);
    cycle();
    drive(0, 1, 1, 1, 1, 2, 'h1234, 0, 0, 'h0000);
    cycle();
    chk("blt_untaken_pc", pc, 'h0010);

    // Immediate decode
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 'hFC02);
    cycle();
    chk("imm_ri", imm, 'hFFFF);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h8001);
    cycle();
    chk("imm_2ri", imm, 'hFFFC);

    // PC wrap
    drive(0, 1, 0, 0, 0, 0, 'hFFFF, 0, 0, 0);
    cycle();
    drive(0, 1, 0, 0, 0, 0, (m_pc + 1) & c_MASK, 0, 0, 0);
    cycle();
    chk("pc_wrap", pc, 'h0000);

    // Illegal opcode, then a legal fetch
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h0005);
    cycle();
`ifdef ILLEGAL_OP_EN
    chk("illegal_set", illegal_op, 1);
`else
    chk("illegal_set", illegal_op, 0);
`endif
    drive(1, 1, 0, 0, 0, 0, 'h0004, 0, 0, 'h1A42);
    cycle();
    chk("illegal_sticky", illegal_op, m_ill);

    // Reset between branch cycles
    drive(0, 0, 0, 0, 0, 0, 'h0020, 0, 0, 0);
    cycle();
    drive(0, 1, 1, 0, 1, 0, 'h0099, 1, 0, 0);
    #2 Reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_pc_now", pc, c_RESET_PC);
    chk("midrst_alu_out", alu_out, 0);
    @(posedge CLK);
    #1;
    chk("midrst_pc_edge", pc, c_RESET_PC);
    @(negedge CLK);
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 'h0055, 0, 0, 0);
    cycle();
    chk("postrst_pc", pc, c_RESET_PC);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, c_MASK), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, c_MASK));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning datapath and instruction width.
REQ-002 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
 CLK  in  1  sole clock; all state updates on posedge.
 Reset  in  1  asynchronous, active-low reset.
 IRWrite  in  1  load IR from mem_rdata.
 PCWrite  in  1  PC write request.
 PCSrc  in  1  PC source: 0 = alu_result, 1 = alu_out register.
 IoD  in  1  memory address select: 0 = PC, 1 = alu_out.
 Branch  in  1  current PC write is conditional.
 BranchType  in  2  00 beq, 01 bne, 10 blt, 11 bge.
 alu_result  in  WIDTH  live ALU output.
 alu_zero  in  1  alu_result == 0.
 alu_lt  in  1  signed A < B from the current ALU operation.
 mem_rdata  in  WIDTH  memory read data.
 mem_addr  out  WIDTH  memory address.
 pc  out  WIDTH  program counter.
 ctrl  out  7  IR[6:0]: funct IR[6:3], opcode IR[2:0]; feeds the control FSM.
 rd / rs1 / rs2  out  3 each  IR[9:7] / IR[12:10] / IR[15:13].
 imm  out  WIDTH  sign-extended immediate selected by opcode.
 alu_out  out  WIDTH  registered ALU result.
 mdr  out  WIDTH  registered memory data.
 br_taken  out  1  combinational branch decision.
 illegal_op  out  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-004 alu_out SHALL capture alu_result on every rising CLK edge.
REQ-005 mdr SHALL capture mem_rdata on every rising CLK edge.
REQ-006 IR SHALL load mem_rdata on the rising edge when IRWrite=1 and SHALL hold otherwise.
REQ-007 br_taken SHALL be: beq -> alu_zero; bne -> !alu_zero; blt -> alu_lt; bge -> !alu_lt.
REQ-008 PC SHALL load the PCSrc-selected value when PCWrite=1 and (Branch=0 or br_taken=1); otherwise PC SHALL hold.
REQ-009 For a taken branch sequence, the first cycle (ALU computes PC+imm) leaves the target in alu_out; the second cycle (PCSrc=1, Branch=1) SHALL load PC from alu_out, so the update lands 2 cycles after branch entry.
REQ-010 imm SHALL be: opcode 001 -> sext(IR[15:13]); 010 -> sext(IR[15:10]); 011 and 100 -> sext(IR[15:7]); 000 and others -> 0.
REQ-011 mem_addr SHALL be IoD ? alu_out : pc, combinationally.
REQ-012 PC arithmetic SHALL wrap modulo 2^WIDTH; 16'hFFFF+1 SHALL give 16'h0000 with no flag.
REQ-013 When IRWrite and PCWrite are both asserted (fetch), IR SHALL receive the instruction at the old PC and PC SHALL update in the same edge.

Reset
REQ-014 When Reset=0, the block SHALL asynchronously set PC=RESET_PC, IR=0, alu_out=0, mdr=0 and illegal_op=0.
REQ-015 Reset asserted between the two branch cycles SHALL discard the pending branch; PC SHALL be RESET_PC after release.
REQ-016 The first rising edge after Reset rises SHALL be a normal update edge.

Configuration
REQ-017 With ILLEGAL_OP_EN defined, illegal_op SHALL set on an IRWrite edge that loads opcode 101, 110 or 111, and SHALL stay set until reset.
REQ-018 Without ILLEGAL_OP_EN, illegal_op SHALL be tied to 0 and no flag register SHALL exist.

Structure
REQ-019 A shared package lime_pkg SHALL hold the opcode constants (000 3R, 001 2RI, 010 RI, 011 L, 100 UJ), the BranchType encodings, the IR field bit positions and the default WIDTH.
REQ-020 Branch decision logic SHALL be a sub-module branch_cond (inputs BranchType, alu_zero, alu_lt; output br_taken).

Verification
REQ-021 Fetch: reset, mem_rdata=16'h1A42, IRWrite=1, PCWrite=1, PCSrc=0, alu_result=16'h0002 -> next edge: ctrl=7'h42, rd=4, rs1=6, rs2=0, pc=16'h0002.
REQ-022 Taken beq: cycle 1 alu_result=16'h0010; cycle 2 Branch=1, BranchType=00, alu_zero=1, PCSrc=1, PCWrite=1 -> pc=16'h0010.
REQ-023 Untaken blt: same sequence with BranchType=10 and alu_lt=0 -> pc unchanged.
REQ-024 Immediate: IR=16'hFC02 (opcode 010) -> imm=16'hFFFF; IR=16'h8001 (opcode 001) -> imm=16'hFFFC.
REQ-025 Reset: Reset=0 mid-cycle between branch cycles -> pc=RESET_PC immediately, with no PC update on the following edge.
REQ-026 Illegal opcode (with ILLEGAL_OP_EN): load IR=16'h0005 -> illegal_op=1, still 1 after a legal fetch; without the macro -> illegal_op=0.
